// File: rtl/uart_pkg.sv
// Shared UART register map and arbiter state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_pkg;

    // UART register byte addresses
    localparam logic [7:0] UART_CTRL           = 8'd0;
    localparam logic [7:0] UART_TX             = 8'd4;
    localparam logic [7:0] UART_RX             = 8'd8;
    localparam logic [7:0] UART_RX_EN          = 8'd12;
    localparam logic [7:0] UART_TX_EN          = 8'd16;
    localparam logic [7:0] UART_RX_STATUS      = 8'd20;
    localparam logic [7:0] UART_TX_STATUS      = 8'd24;
    localparam logic [7:0] UART_INTR_EN        = 8'd28;
    localparam logic [7:0] UART_INTR_STATUS    = 8'd32;
    localparam logic [7:0] UART_BAUD_DIV       = 8'd36;
    localparam logic [7:0] UART_PARITY         = 8'd40;
    localparam logic [7:0] UART_STOP_BITS      = 8'd44;
    localparam logic [7:0] UART_TX_BUFFER_SIZE = 8'd48;
    localparam logic [7:0] UART_RX_BUFFER_SIZE = 8'd52;

    // Arbiter FSM: round-robin among all, or a single locked owner
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin one-hot grant: first requester at or after ptr_i wins.
// Latency: purely combinational.
// Backpressure: requesters not granted simply see gnt_o low and keep requesting.
module uart_rr_arb #(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    int   idx;
    logic found;

    // Scan requesters starting at the pointer, wrapping once around
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one UART register port among NREQ requesters, round-robin or locked burst.
// Latency: grant combinational; downstream strobe +1 cycle; read data/rvalid +2 cycles.
// Backpressure: ungranted requesters stall, holding req/addr/data until gnt_o.
module uart_port_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      lock_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ-1:0]      ren_i,
    input  logic [NREQ-1:0][7:0] addr_i,
    input  logic [NREQ-1:0][31:0] wdata_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [31:0]          rdata_o,
    output logic [NREQ-1:0]      err_o,
    output logic                 timeout_o,
    output logic                 uart_we_o,
    output logic                 uart_ren_o,
    output logic [7:0]           uart_addr_o,
    output logic [31:0]          uart_wdata_o,
    input  logic [31:0]          uart_rdata_i,
    input  logic                 intr_tx_i,
    input  logic                 intr_rx_i,
    output logic [NREQ-1:0]      intr_tx_o,
    output logic [NREQ-1:0]      intr_rx_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT - 1);

    arb_state_e      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   lock_cnt;
    logic [IW-1:0]   tx_owner;
    logic [IW-1:0]   rx_owner;
    logic [IW-1:0]   rd_who;
    logic [NREQ-1:0] rr_gnt;
    logic            acc;
    logic [IW-1:0]   acc_idx;
    logic            acc_we;
    logic            acc_ren;
    logic            acc_legal;
    logic [7:0]      acc_addr;
    logic [IW-1:0]   next_ptr;

    uart_rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .req_i (req_i),
        .ptr_i (rr_ptr),
        .gnt_o (rr_gnt)
    );

    // Grant: round-robin when idle, owner only while locked
    always_comb begin
        gnt_o = rr_gnt;
        if (state == ARB_LOCKED) begin
            gnt_o        = '0;
            gnt_o[owner] = req_i[owner];
        end
    end

    // Identify the accepted requester (gnt_o is one-hot or zero)
    always_comb begin
        acc     = 1'b0;
        acc_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && gnt_o[i]) begin
                acc     = 1'b1;
                acc_idx = IW'(i);
            end
        end
    end

    assign acc_we    = we_i[acc_idx];
    assign acc_ren   = ren_i[acc_idx];
    assign acc_legal = acc && (acc_we ^ acc_ren);
    assign acc_addr  = addr_i[acc_idx];
    assign next_ptr  = (acc_idx == IW'(NREQ - 1)) ? '0 : acc_idx + 1'b1;

    // Arbitration FSM: pointer advance, lock entry, release and timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lock_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            if (acc) begin
                rr_ptr <= next_ptr;
            end
            case (state)
                ARB_IDLE: begin
                    if (acc && lock_i[acc_idx]) begin
                        state    <= ARB_LOCKED;
                        owner    <= acc_idx;
                        lock_cnt <= '0;
                    end
                end
                ARB_LOCKED: begin
                    // A voluntary release wins over a simultaneous timeout
                    if (!lock_i[owner]) begin
                        state    <= ARB_IDLE;
                        lock_cnt <= '0;
                    end else if (lock_cnt == CNT_MAX) begin
                        state     <= ARB_IDLE;
                        lock_cnt  <= '0;
                        timeout_o <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Downstream strobes, read return, error pulses and interrupt ownership
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            uart_we_o    <= 1'b0;
            uart_ren_o   <= 1'b0;
            uart_addr_o  <= '0;
            uart_wdata_o <= '0;
            err_o        <= '0;
            rvalid_o     <= '0;
            rdata_o      <= '0;
            rd_who       <= '0;
            tx_owner     <= '0;
            rx_owner     <= '0;
        end else begin
            uart_we_o    <= acc_legal && acc_we;
            uart_ren_o   <= acc_legal && acc_ren;
            uart_addr_o  <= acc_legal ? acc_addr : '0;
            uart_wdata_o <= acc_legal ? wdata_i[acc_idx] : '0;
            rd_who       <= acc_idx;

            err_o <= '0;
            if (acc && !acc_legal) begin
                err_o[acc_idx] <= 1'b1;
            end

            // Read data is captured in the strobe cycle, one pop per read
            rvalid_o <= '0;
            rdata_o  <= '0;
            if (uart_ren_o) begin
                rvalid_o[rd_who] <= 1'b1;
                rdata_o          <= uart_rdata_i;
            end

            if (acc_legal && acc_we && (acc_addr == UART_TX || acc_addr == UART_TX_EN)) begin
                tx_owner <= acc_idx;
            end
            if (acc_legal && acc_we && acc_addr == UART_RX_EN) begin
                rx_owner <= acc_idx;
            end
        end
    end

    // Interrupts go only to the requester that last configured each direction
    always_comb begin
        intr_tx_o           = '0;
        intr_rx_o           = '0;
        intr_tx_o[tx_owner] = intr_tx_i;
        intr_rx_o[rx_owner] = intr_rx_i;
    end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: directed scenarios plus randomized traffic vs a model.
// Latency: checks gnt comb, strobes at +1, read data at +2.
// Backpressure: random requesters hold their pending op until granted.
module tb_uart_port_arbiter;

    localparam int NREQ = 2;
    localparam int LT   = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       req_i, lock_i, we_i, ren_i;
    logic [1:0][7:0]  addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       gnt_o, rvalid_o, err_o, intr_tx_o, intr_rx_o;
    logic [31:0]      rdata_o, uart_wdata_o, uart_rdata_i;
    logic             timeout_o, uart_we_o, uart_ren_o, intr_tx_i, intr_rx_i;
    logic [7:0]       uart_addr_o;

    int checks = 0;
    int errors = 0;

    uart_port_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i),
        .we_i(we_i), .ren_i(ren_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .timeout_o(timeout_o), .uart_we_o(uart_we_o), .uart_ren_o(uart_ren_o),
        .uart_addr_o(uart_addr_o), .uart_wdata_o(uart_wdata_o), .uart_rdata_i(uart_rdata_i),
        .intr_tx_i(intr_tx_i), .intr_rx_i(intr_rx_i), .intr_tx_o(intr_tx_o), .intr_rx_o(intr_rx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = '0; lock_i = '0; we_i = '0; ren_i = '0;
        addr_i = '0; wdata_i = '0; uart_rdata_i = '0;
        intr_tx_i = 1'b0; intr_rx_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        tick();
        intr_tx_i = 1'b1; intr_rx_i = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if ({uart_we_o, uart_ren_o, uart_addr_o, uart_wdata_o} !== 42'd0) begin errors++; $display("FAIL reset_strobes: we=%b ren=%b addr=%h wdata=%h want all 0", uart_we_o, uart_ren_o, uart_addr_o, uart_wdata_o); end
        checks++; if ({rvalid_o, err_o, timeout_o, rdata_o} !== 37'd0) begin errors++; $display("FAIL reset_outs: rvalid=%b err=%b to=%b rdata=%h want all 0", rvalid_o, err_o, timeout_o, rdata_o); end
        checks++; if ({intr_tx_o, intr_rx_o} !== 4'b0101) begin errors++; $display("FAIL reset_intr_owner: tx=%b rx=%b want 01 01", intr_tx_o, intr_rx_o); end
        intr_tx_i = 1'b0; intr_rx_i = 1'b0;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_rr_writes();
        req_i = 2'b11; we_i = 2'b11; addr_i[0] = 8'd0; addr_i[1] = 8'd4;
        wdata_i[0] = 32'hA0A0_0001; wdata_i[1] = 32'hB1B1_0002;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_first_gnt: got %b want 01", gnt_o); end
        tick();
        req_i = 2'b10;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rr_second_gnt: got %b want 10", gnt_o); end
        checks++; if (uart_we_o !== 1'b1 || uart_addr_o !== 8'd0 || uart_wdata_o !== 32'hA0A0_0001) begin errors++; $display("FAIL rr_write0: we=%b addr=%0d wdata=%h want 1 0 a0a00001", uart_we_o, uart_addr_o, uart_wdata_o); end
        tick();
        idle_inputs();
        checks++; if (uart_we_o !== 1'b1 || uart_addr_o !== 8'd4 || uart_wdata_o !== 32'hB1B1_0002) begin errors++; $display("FAIL rr_write1: we=%b addr=%0d wdata=%h want 1 4 b1b10002", uart_we_o, uart_addr_o, uart_wdata_o); end
        tick();
        checks++; if (uart_we_o !== 1'b0 || uart_addr_o !== 8'd0) begin errors++; $display("FAIL rr_write_end: we=%b addr=%0d want 0 0", uart_we_o, uart_addr_o); end
    endtask

    task automatic test_read();
        int ren_cycles;
        ren_cycles = 0;
        req_i = 2'b10; ren_i = 2'b10; addr_i[1] = 8'd8;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL read_gnt: got %b want 10", gnt_o); end
        tick();
        idle_inputs();
        uart_rdata_i = 32'h41;
        if (uart_ren_o) ren_cycles++;
        checks++; if (uart_addr_o !== 8'd8) begin errors++; $display("FAIL read_addr: got %0d want 8", uart_addr_o); end
        tick();
        uart_rdata_i = 32'h99;
        if (uart_ren_o) ren_cycles++;
        checks++; if (rvalid_o !== 2'b10 || rdata_o !== 32'h41) begin errors++; $display("FAIL read_data: rvalid=%b rdata=%h want 10 41", rvalid_o, rdata_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (uart_ren_o) ren_cycles++;
        end
        checks++; if (ren_cycles !== 1) begin errors++; $display("FAIL read_ren_count: got %0d want 1", ren_cycles); end
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL read_rvalid_clear: got %b want 00", rvalid_o); end
    endtask

    task automatic test_lock_timeout();
        req_i = 2'b01; lock_i = 2'b01; we_i = 2'b01; addr_i[0] = 8'd0;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_gnt: got %b want 01", gnt_o); end
        tick();
        req_i = 2'b10; we_i = 2'b10; addr_i[1] = 8'd0;
        for (int i = 0; i < LT; i++) begin
            #1;
            checks++; if (gnt_o[1] !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL lock_stall%0d: gnt1=%b to=%b want 0 0", i, gnt_o[1], timeout_o); end
            tick();
        end
        #1;
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL lock_timeout_pulse: got %b want 1", timeout_o); end
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL lock_after_gnt: got %b want 10", gnt_o); end
        tick();
        idle_inputs();
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL lock_timeout_one_cycle: got %b want 0", timeout_o); end
        tick();
    endtask

    task automatic test_illegal();
        req_i = 2'b01; we_i = 2'b01; ren_i = 2'b01; addr_i[0] = 8'd4;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL illegal_gnt: got %b want 01", gnt_o); end
        tick();
        idle_inputs();
        checks++; if (err_o !== 2'b01 || uart_we_o !== 1'b0 || uart_ren_o !== 1'b0) begin errors++; $display("FAIL illegal_drop: err=%b we=%b ren=%b want 01 0 0", err_o, uart_we_o, uart_ren_o); end
        tick();
        checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL illegal_err_clear: got %b want 00", err_o); end
    endtask

    task automatic test_intr();
        req_i = 2'b10; we_i = 2'b10; addr_i[1] = 8'd16;
        tick();
        idle_inputs();
        intr_tx_i = 1'b1;
        #1;
        checks++; if (intr_tx_o !== 2'b10) begin errors++; $display("FAIL intr_tx_route: got %b want 10", intr_tx_o); end
        req_i = 2'b01; we_i = 2'b01; addr_i[0] = 8'd12;
        tick();
        idle_inputs();
        intr_tx_i = 1'b1; intr_rx_i = 1'b1;
        #1;
        checks++; if (intr_rx_o !== 2'b01 || intr_tx_o !== 2'b10) begin errors++; $display("FAIL intr_rx_route: rx=%b tx=%b want 01 10", intr_rx_o, intr_tx_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        req_i = 2'b01; lock_i = 2'b01; ren_i = 2'b01; addr_i[0] = 8'd8;
        tick();
        uart_rdata_i = 32'h77;
        rst_ni = 1'b0;
        #1;
        checks++; if (uart_ren_o !== 1'b0) begin errors++; $display("FAIL rstmid_ren: got %b want 0", uart_ren_o); end
        idle_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL rstmid_rvalid%0d: got %b want 00", i, rvalid_o); end
        end
        req_i = 2'b10;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rstmid_unlocked: got %b want 10", gnt_o); end
        req_i = 2'b11;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rstmid_ptr0: got %b want 01", gnt_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit          pend [2];
        bit          p_we [2];
        bit          p_ren [2];
        logic [7:0]  p_addr [2];
        logic [31:0] p_wd [2];
        bit          m_lock;
        int          m_own, m_ptr, m_cnt, m_tx, m_rx, w, kind, e_rwho;
        logic        e_we, e_ren, e_to, n_we, n_ren, n_to;
        logic [7:0]  e_addr, n_addr;
        logic [31:0] e_wd, n_wd, e_rd, n_rd;
        logic [1:0]  e_err, n_err, e_rv, n_rv, exp_g, exp_tx, exp_rx;

        do_reset();
        m_lock = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_tx = 0; m_rx = 0; e_rwho = 0;
        e_we = 0; e_ren = 0; e_to = 0; e_addr = '0; e_wd = '0; e_rd = '0; e_err = '0; e_rv = '0;
        for (int r = 0; r < NREQ; r++) begin
            pend[r] = 0; p_we[r] = 0; p_ren[r] = 0; p_addr[r] = '0; p_wd[r] = '0;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (uart_we_o !== e_we || uart_ren_o !== e_ren || uart_addr_o !== e_addr ||
                (e_we && uart_wdata_o !== e_wd) || err_o !== e_err || timeout_o !== e_to ||
                rvalid_o !== e_rv || (e_rv != 2'b00 && rdata_o !== e_rd)) begin
                errors++;
                $display("FAIL rand_regs cyc%0d: we=%b/%b ren=%b/%b addr=%h/%h wd=%h/%h err=%b/%b to=%b/%b rv=%b/%b rd=%h/%h (got/want)",
                         cyc, uart_we_o, e_we, uart_ren_o, e_ren, uart_addr_o, e_addr, uart_wdata_o, e_wd,
                         err_o, e_err, timeout_o, e_to, rvalid_o, e_rv, rdata_o, e_rd);
            end

            for (int r = 0; r < NREQ; r++) begin
                if (!pend[r] && ($urandom % 3) == 0) begin
                    pend[r] = 1;
                    kind = int'($urandom % 8);
                    if (kind < 4)      begin p_we[r] = 1; p_ren[r] = 0; end
                    else if (kind < 7) begin p_we[r] = 0; p_ren[r] = 1; end
                    else begin p_we[r] = $urandom % 2; p_ren[r] = p_we[r]; end
                    p_addr[r] = 8'($urandom_range(0, 5) * 4);
                    p_wd[r]   = $urandom;
                end
                req_i[r]   = pend[r] && (($urandom % 4) != 0);
                lock_i[r]  = ($urandom % 6) != 0;
                we_i[r]    = p_we[r];
                ren_i[r]   = p_ren[r];
                addr_i[r]  = p_addr[r];
                wdata_i[r] = p_wd[r];
            end
            intr_tx_i    = $urandom % 2;
            intr_rx_i    = $urandom % 2;
            uart_rdata_i = $urandom;
            #1;

            exp_g = '0;
            if (m_lock) begin
                exp_g[m_own] = req_i[m_own];
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (exp_g == 2'b00 && req_i[(m_ptr + k) % NREQ]) exp_g[(m_ptr + k) % NREQ] = 1'b1;
                end
            end
            checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL rand_gnt cyc%0d: got %b want %b", cyc, gnt_o, exp_g); end
            exp_tx = '0; exp_tx[m_tx] = intr_tx_i;
            exp_rx = '0; exp_rx[m_rx] = intr_rx_i;
            checks++; if (intr_tx_o !== exp_tx || intr_rx_o !== exp_rx) begin errors++; $display("FAIL rand_intr cyc%0d: tx=%b rx=%b want %b %b", cyc, intr_tx_o, intr_rx_o, exp_tx, exp_rx); end

            n_rv = '0; n_rd = '0;
            if (e_ren) begin n_rv[e_rwho] = 1'b1; n_rd = uart_rdata_i; end
            n_we = 0; n_ren = 0; n_addr = '0; n_wd = '0; n_err = '0; n_to = 0;
            w = -1;
            for (int k = 0; k < NREQ; k++) if (exp_g[k]) w = k;
            if (w >= 0) begin
                if (we_i[w] != ren_i[w]) begin
                    n_we = we_i[w]; n_ren = ren_i[w]; n_addr = addr_i[w]; n_wd = wdata_i[w];
                    if (we_i[w] && (addr_i[w] == 8'd4 || addr_i[w] == 8'd16)) m_tx = w;
                    if (we_i[w] && addr_i[w] == 8'd12) m_rx = w;
                end else begin
                    n_err[w] = 1'b1;
                end
                m_ptr   = (w + 1) % NREQ;
                pend[w] = 0;
                e_rwho  = w;
            end
            if (!m_lock) begin
                if (w >= 0 && lock_i[w]) begin m_lock = 1; m_own = w; m_cnt = 0; end
            end else if (!lock_i[m_own]) begin
                m_lock = 0;
            end else if (m_cnt == LT - 1) begin
                m_lock = 0; n_to = 1;
            end else begin
                m_cnt++;
            end

            e_we = n_we; e_ren = n_ren; e_addr = n_addr; e_wd = n_wd; e_err = n_err;
            e_to = n_to; e_rv = n_rv; e_rd = n_rd;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rr_writes();
        test_read();
        test_lock_timeout();
        test_illegal();
        test_intr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_port_arbiter.md
UART_PORT_ARBITER -- requirements
Module: uart_port_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of requesters (legal range 2..4).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 256, giving the maximum cycles a locked owner may hold the port (legal range >= 2).
REQ-003 clk_i  in  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 req_i  in  NREQ  per-requester access request.
REQ-006 lock_i  in  NREQ  per-requester burst lock request.
REQ-007 we_i / ren_i  in  NREQ each  per-requester write / read strobe.
REQ-008 addr_i  in  NREQ x 8  per-requester register byte address.
REQ-009 wdata_i  in  NREQ x 32  per-requester write data.
REQ-010 gnt_o  out  NREQ  access accepted this cycle (one-hot or zero).
REQ-011 rvalid_o  out  NREQ  read data valid for that requester.
REQ-012 rdata_o  out  32  shared read data.
REQ-013 err_o  out  NREQ  one-cycle pulse on an illegal access.
REQ-014 timeout_o  out  1  one-cycle pulse on a forced lock release.
REQ-015 uart_we_o, uart_ren_o  out  1 each; uart_addr_o  out  8; uart_wdata_o  out  32; uart_rdata_i  in  32: downstream UART register port.
REQ-016 intr_tx_i, intr_rx_i  in  1 each; intr_tx_o, intr_rx_o  out  NREQ each: interrupt routing.

Function
REQ-017 The FSM SHALL have two states: IDLE (round-robin arbitration) and LOCKED (single owner).
REQ-018 gnt_o SHALL be combinational from req_i and the registered state; the access is accepted at the edge where req_i[w] and gnt_o[w] are both high.
REQ-019 In IDLE, priority SHALL start at rr_ptr; after each grant to w, rr_ptr SHALL become (w+1) mod NREQ.
REQ-020 A grant in IDLE with lock_i[w]=1 SHALL move the FSM to LOCKED with owner=w and lock counter=0.
REQ-021 In LOCKED, only the owner SHALL be granted, with no arbitration; all other requests SHALL stall.
REQ-022 LOCKED SHALL return to IDLE on the edge where lock_i[owner]=0, or when the counter reaches LOCK_TIMEOUT-1; the timeout case also pulses timeout_o.
REQ-023 The lock counter SHALL increment every LOCKED cycle, whether or not the owner requests.
REQ-024 An accepted access SHALL drive uart_we_o or uart_ren_o, uart_addr_o and uart_wdata_o as registered one-cycle pulses in the cycle after acceptance; all are zero otherwise.
REQ-025 Throughput SHALL be one access per cycle.
REQ-026 For a read, uart_rdata_i SHALL be sampled in the strobe cycle and presented on rdata_o with rvalid_o[w] one cycle later, i.e. two cycles after acceptance.
REQ-027 uart_ren_o SHALL never exceed one cycle per accepted read, because downstream reads pop a FIFO.
REQ-028 An access with both we_i and ren_i high, or with neither high, SHALL be granted and dropped: no downstream strobe, and err_o[w] pulses one cycle after acceptance.
REQ-029 tx_owner SHALL be updated to w on an accepted write to address 4 (TX data) or 16 (TX enable).
REQ-030 rx_owner SHALL be updated to w on an accepted write to address 12 (RX enable).
REQ-031 intr_tx_o SHALL equal intr_tx_i on bit tx_owner only, and intr_rx_o SHALL equal intr_rx_i on bit rx_owner only; both are combinational.
REQ-032 A requester that drops req_i before gnt_o is seen SHALL lose nothing; requesters SHALL hold addr/data stable until granted.

Reset
REQ-033 Reset SHALL set: state=IDLE, rr_ptr=0, owner=0, counter=0, tx_owner=rx_owner=0.
REQ-034 Reset SHALL force all registered outputs (uart strobes, addr, wdata, rdata_o, rvalid_o, err_o, timeout_o) to 0.
REQ-035 Reset mid-burst or mid-read SHALL discard the in-flight access, with no rvalid_o after release.

Structure
REQ-036 Shared package uart_pkg SHALL hold: UART register address constants (CTRL 0, TX 4, RX 8, RX_EN 12, TX_EN 16, RX_STATUS 20, ... RX_BUFFER_SIZE 52) and the arbiter state enum.
REQ-037 One sub-module, uart_rr_arb (NREQ-wide round-robin grant from req and pointer), SHALL be instantiated.
REQ-038 Target size is 150-250 lines of RTL.

Verification
REQ-039 After reset, req_i=2'b11 as writes to addrs 0 and 4 -> gnt_o 01 then 10 on consecutive cycles; uart_we_o high two consecutive cycles with addr 0 then 4.
REQ-040 Requester 1 reads addr 8 with uart_rdata_i=0x41 -> uart_ren_o high exactly 1 cycle; rvalid_o=2'b10 and rdata_o=0x41 two cycles after acceptance.
REQ-041 LOCK_TIMEOUT=4; requester 0 locks and holds lock; requester 1 requests -> gnt_o[1]=0 for 4 cycles, timeout_o pulse, then gnt_o[1]=1.
REQ-042 Requester 0 asserts we_i and ren_i together -> gnt_o[0]=1, err_o[0] pulse, uart_we_o=uart_ren_o=0.
REQ-043 Requester 1 writes addr 16, then intr_tx_i=1 -> intr_tx_o=2'b10; requester 0 writes addr 12, then intr_rx_i=1 -> intr_rx_o=2'b01.
REQ-044 rst_ni low during LOCKED with a read in flight -> state IDLE, no rvalid_o, next request arbitrates from rr_ptr=0.
